// File: rtl/floating_point_mul_pipe.sv
// Pipelined floating-point multiplier: valid/ready handshake, opaque tag, flush-to-zero inputs.
// Define FP_MUL_STICKY_FLAGS_EN to add flags_clear / sticky_flags.
module floating_point_mul_pipe #(
  parameter int exp_width   = 8,
  parameter int frac_width  = 23,
  parameter int pipe_stages = 3,
  parameter int tag_width   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [exp_width+frac_width:0]  op1,
  input  logic [exp_width+frac_width:0]  op2,
  input  logic [1:0]                     round_mode,
  input  logic [tag_width-1:0]           in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [exp_width+frac_width:0]  result,
  output logic [tag_width-1:0]           out_tag,
  output logic [4:0]                     exception
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic                           flags_clear,
  output logic [4:0]                     sticky_flags
`endif
);
  localparam int W  = exp_width + frac_width + 1;
  localparam int EW = exp_width;
  localparam int F  = frac_width;
  localparam int PW = 2 * F + 2;
  localparam int XW = EW + 2;

  localparam logic [1:0] FP_ROUND_TONEAREST  = 2'd0;
  localparam logic [1:0] FP_ROUND_TOWARDZERO = 2'd1;
  localparam logic [1:0] FP_ROUND_DOWNWARD   = 2'd2;
  localparam logic [1:0] FP_ROUND_UPWARD     = 2'd3;
  localparam int FP_INEXACT   = 0;
  localparam int FP_UNDERFLOW = 1;
  localparam int FP_OVERFLOW  = 2;
  localparam int FP_INVALID   = 4;

  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0] EXP_TOP  = EXP_ONES - 1'b1;
  localparam logic [W-1:0]  QUIET    = W'(1) << (F - 1);
  localparam logic signed [XW-1:0] BIAS      = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_LIMIT = XW'((1 << EW) - 1);

  typedef struct packed {
    logic                  valid;
    logic [tag_width-1:0]  tag;
    logic [1:0]            rm;
    logic                  sign;
    logic                  special;
    logic [W-1:0]          spec_res;
    logic [4:0]            spec_exc;
    logic [XW-1:0]         exp;
    logic [PW-1:0]         prod;
  } stage_t;

  logic                 stall;
  logic                 cap_valid;
  logic [W-1:0]         cap_op1, cap_op2;
  logic [1:0]           cap_rm;
  logic [tag_width-1:0] cap_tag;
  stage_t               s1;
  stage_t               pipe [1:pipe_stages-1];
  stage_t               fin;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign fin      = pipe[pipe_stages-1];

  logic [EW-1:0] ea, eb;
  logic [F-1:0]  fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = cap_op1[W-2 -: EW];
  assign eb     = cap_op2[W-2 -: EW];
  assign fa     = cap_op1[F-1:0];
  assign fb     = cap_op2[F-1:0];
  // A zero exponent field covers both true zero and subnormals (flushed).
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  always_comb begin
    s1         = '0;
    s1.valid   = cap_valid;
    s1.tag     = cap_tag;
    s1.rm      = cap_rm;
    s1.sign    = cap_op1[W-1] ^ cap_op2[W-1];
    s1.exp     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s1.prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});
    s1.special = 1'b1;
    if (a_nan) begin
      s1.spec_res = cap_op1 | QUIET;
    end else if (b_nan) begin
      s1.spec_res = cap_op2 | QUIET;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      s1.spec_res             = {1'b1, EXP_ONES, 1'b1, {(F-1){1'b0}}};
      s1.spec_exc[FP_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      s1.spec_res = {s1.sign, EXP_ONES, {F{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1.spec_res = {s1.sign, {(W-1){1'b0}}};
    end else begin
      s1.special = 1'b0;
    end
  end

  logic [PW-1:0]        shifted;
  logic                 g, r, s, lsb, lost, inc;
  logic signed [XW-1:0] e_n, e_r;
  logic [XW+F-1:0]      rounded;
  logic [W-1:0]         res_n;
  logic [4:0]           exc_n;
  logic                 unused_msb;

  assign unused_msb = shifted[PW-1];

  always_comb begin
    shifted = fin.prod[PW-1] ? fin.prod : (fin.prod << 1);
    e_n     = $signed(fin.exp) + $signed({{(XW-1){1'b0}}, fin.prod[PW-1]});
    g       = shifted[F];
    r       = shifted[F-1];
    s       = |shifted[F-2:0];
    lsb     = shifted[F+1];
    lost    = g | r | s;
    case (fin.rm)
      FP_ROUND_TONEAREST:  inc = g & (r | s | lsb);
      FP_ROUND_TOWARDZERO: inc = 1'b0;
      FP_ROUND_DOWNWARD:   inc = lost & fin.sign;
      FP_ROUND_UPWARD:     inc = lost & ~fin.sign;
      default:             inc = 1'b0;
    endcase
    // Exponent sits directly above the fraction so the round carry ripples into it.
    rounded = {e_n, shifted[PW-2 -: F]} + {{(XW+F-1){1'b0}}, inc};
    e_r     = rounded[XW+F-1 -: XW];
    exc_n   = '0;
    if (fin.special) begin
      res_n = fin.spec_res;
      exc_n = fin.spec_exc;
    end else if (e_r <= 0) begin
      res_n               = {fin.sign, {(W-1){1'b0}}};
      exc_n[FP_UNDERFLOW] = 1'b1;
      exc_n[FP_INEXACT]   = 1'b1;
    end else if (e_r >= EXP_LIMIT) begin
      exc_n[FP_OVERFLOW] = 1'b1;
      exc_n[FP_INEXACT]  = 1'b1;
      if ((fin.rm == FP_ROUND_TONEAREST) ||
          (fin.rm == FP_ROUND_UPWARD && !fin.sign) ||
          (fin.rm == FP_ROUND_DOWNWARD && fin.sign))
        res_n = {fin.sign, EXP_ONES, {F{1'b0}}};
      else
        res_n = {fin.sign, EXP_TOP, {F{1'b1}}};
    end else begin
      res_n             = {fin.sign, e_r[EW-1:0], rounded[F-1:0]};
      exc_n[FP_INEXACT] = lost;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_op1   <= '0;
      cap_op2   <= '0;
      cap_rm    <= '0;
      cap_tag   <= '0;
      for (int k = 1; k < pipe_stages; k++) pipe[k] <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      exception <= '0;
    end else if (!stall) begin
      cap_valid <= in_valid;
      cap_op1   <= op1;
      cap_op2   <= op2;
      cap_rm    <= round_mode;
      cap_tag   <= in_tag;
      pipe[1]   <= s1;
      for (int k = 2; k < pipe_stages; k++) pipe[k] <= pipe[k-1];
      out_valid <= fin.valid;
      result    <= res_n;
      out_tag   <= fin.tag;
      exception <= exc_n;
    end
  end

`ifdef FP_MUL_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || flags_clear)
      sticky_flags <= '0;
    else if (out_valid && out_ready)
      sticky_flags <= sticky_flags | exception;
  end
`endif

endmodule

// File: tb/tb_floating_point_mul_pipe.sv
// Self-checking bench for floating_point_mul_pipe (binary32, 3 stages) against an integer-arithmetic reference.
`timescale 1ns/1ps
module tb_floating_point_mul_pipe;
  localparam int N = 3;
  localparam logic [1:0] RM_NE = 2'd0, RM_TZ = 2'd1, RM_DN = 2'd2, RM_UP = 2'd3;
  localparam logic [4:0] X_INV = 5'b10000, X_OVF = 5'b00100, X_UF = 5'b00010, X_IX = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [1:0]  round_mode;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  exception;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic        flags_clear;
  logic [4:0]  sticky_flags;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  exc;
    logic [3:0]  tag;
  } exp_t;
  exp_t       exp_q[$];
  logic [3:0] got_tags[$];

  always #5 clk = ~clk;

  floating_point_mul_pipe #(.exp_width(8), .frac_width(23), .pipe_stages(N), .tag_width(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .round_mode(round_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .exception(exception)
`ifdef FP_MUL_STICKY_FLAGS_EN
    , .flags_clear(flags_clear), .sticky_flags(sticky_flags)
`endif
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, want);
    end
  endtask

  // Reference: exact integer product, then rounding decided from the discarded remainder.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    int ea, eb, e, sh;
    logic sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    longint unsigned prod, kept, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sign   = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan) return {5'b0, a | 32'h0040_0000};
    if (b_nan) return {5'b0, b | 32'h0040_0000};
    if ((a_inf && b_zero) || (a_zero && b_inf)) return {X_INV, 32'hFFC0_0000};
    if (a_inf || b_inf) return {5'b0, sign, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {5'b0, sign, 31'h0};
    prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    kept = prod >> sh;
    rem  = prod - (kept << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      RM_NE:   up = (rem > half) || ((rem == half) && kept[0]);
      RM_TZ:   up = 1'b0;
      RM_DN:   up = sign && (rem != 0);
      default: up = !sign && (rem != 0);
    endcase
    if (up) kept = kept + 1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e <= 0) return {X_UF | X_IX, sign, 31'h0};
    if (e >= 255) begin
      if (rm == RM_NE || (rm == RM_UP && !sign) || (rm == RM_DN && sign))
        return {X_OVF | X_IX, sign, 8'hFF, 23'h0};
      return {X_OVF | X_IX, sign, 8'hFE, 23'h7FFFFF};
    end
    return {(rem != 0) ? X_IX : 5'b0, sign, e[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'h01;
      3:       e = 8'hFE;
      4:       return {1'($urandom), 8'hFF, 23'h0};
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Scoreboard: queue expectations on input transfers, compare on output transfers.
  always @(negedge clk) begin
    exp_t want;
    logic [36:0] m;
    if (!rst) begin
      check("in_ready_vs_stall", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        got_tags.push_back(out_tag);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output observed=tag %0h expected=no output", out_tag);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("sb_result", 64'(result), 64'(want.res));
          check("sb_exception", 64'(exception), 64'(want.exc));
          check("sb_tag", 64'(out_tag), 64'(want.tag));
        end
      end
      if (in_valid && in_ready) begin
        m        = model(op1, op2, round_mode);
        want.res = m[31:0];
        want.exc = m[36:32];
        want.tag = in_tag;
        exp_q.push_back(want);
      end
    end
  end

  task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input logic [3:0] tag,
                           input logic [31:0] want_res, input logic [4:0] want_exc);
    @(posedge clk); #1;
    op1 = a; op2 = b; round_mode = rm; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N - 1) @(posedge clk);
    #1;
    check({name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_result"}, 64'(result), 64'(want_res));
    check({name, "_exc"}, 64'(exception), 64'(want_exc));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    int idx, stall_cycles;
    logic acc, stale;
    in_valid = 1'b0; op1 = '0; op2 = '0; round_mode = RM_NE; in_tag = '0; out_ready = 1'b1;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flags_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_exception", 64'(exception), 64'd0);
    rst = 1'b0;

    single_op("mul_2x3", 32'h4000_0000, 32'h4040_0000, RM_NE, 4'd5, 32'h40C0_0000, 5'b0);
    single_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, RM_NE, 4'd1, 32'hFFC0_0000, X_INV);
    single_op("snan_quiet", 32'h7FA0_0000, 32'h3F80_0000, RM_NE, 4'd2, 32'h7FE0_0000, 5'b0);
    single_op("ovf_ne", 32'h7F7F_FFFF, 32'h4000_0000, RM_NE, 4'd3, 32'h7F80_0000, X_OVF | X_IX);
    single_op("ovf_tz", 32'h7F7F_FFFF, 32'h4000_0000, RM_TZ, 4'd4, 32'h7F7F_FFFF, X_OVF | X_IX);
    single_op("ovf_dn", 32'h7F7F_FFFF, 32'h4000_0000, RM_DN, 4'd6, 32'h7F7F_FFFF, X_OVF | X_IX);
    single_op("ovf_up", 32'h7F7F_FFFF, 32'h4000_0000, RM_UP, 4'd7, 32'h7F80_0000, X_OVF | X_IX);
    single_op("ovf_neg_dn", 32'hFF7F_FFFF, 32'h4000_0000, RM_DN, 4'd8, 32'hFF80_0000, X_OVF | X_IX);
    single_op("ovf_neg_up", 32'hFF7F_FFFF, 32'h4000_0000, RM_UP, 4'd9, 32'hFF7F_FFFF, X_OVF | X_IX);
    single_op("underflow", 32'h0080_0000, 32'h0080_0000, RM_NE, 4'd10, 32'h0000_0000, X_UF | X_IX);
    single_op("subnorm_flush", 32'h8040_0000, 32'h3F80_0000, RM_NE, 4'd11, 32'h8000_0000, 5'b0);
    single_op("neg_inf_fin", 32'hFF80_0000, 32'h4000_0000, RM_NE, 4'd12, 32'hFF80_0000, 5'b0);
    single_op("round_ne", 32'h3F80_0001, 32'h3F80_0001, RM_NE, 4'd13, 32'h3F80_0002, X_IX);
    single_op("round_up", 32'h3F80_0001, 32'h3F80_0001, RM_UP, 4'd14, 32'h3F80_0003, X_IX);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      op1        = rand_fp();
      op2        = rand_fp();
      round_mode = 2'($urandom_range(0, 3));
      in_tag     = 4'($urandom);
      out_ready  = ($urandom_range(0, 4) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_random", 64'(exp_q.size()), 64'd0);

    // Eight tagged ops with a four-cycle consumer stall in the middle.
    @(posedge clk); #1;
    got_tags.delete();
    idx = 0; acc = 1'b0; stall_cycles = 0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      if (acc) idx++;
      in_valid   = (idx < 8);
      in_tag     = 4'(idx);
      op1        = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      op2        = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      round_mode = RM_NE;
      out_ready  = !(cyc >= 6 && cyc < 10);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) stall_cycles++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("stream_accepted", 64'(idx), 64'd8);
    check("stream_stall_cycles", 64'(stall_cycles), 64'd4);
    check("stream_count", 64'(got_tags.size()), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("stream_tag%0d", i), 64'(got_tags[i]), 64'(i));

    // Reset with three ops in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      op1 = 32'h3FC0_0000; op2 = 32'h4000_0000; round_mode = RM_NE;
      in_tag = 4'(i); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("flush_no_stale", 64'(stale), 64'd0);

`ifdef FP_MUL_STICKY_FLAGS_EN
    @(posedge clk); #1;
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    check("sticky_cleared_start", 64'(sticky_flags), 64'd0);
    single_op("sticky_ovf", 32'h7F7F_FFFF, 32'h4000_0000, RM_NE, 4'd1, 32'h7F80_0000, X_OVF | X_IX);
    single_op("sticky_inv", 32'h0000_0000, 32'hFF80_0000, RM_NE, 4'd2, 32'hFFC0_0000, X_INV);
    @(posedge clk); #1;
    check("sticky_accum", 64'(sticky_flags), 64'(X_OVF | X_IX | X_INV));
    repeat (3) @(posedge clk);
    #1;
    check("sticky_hold", 64'(sticky_flags), 64'(X_OVF | X_IX | X_INV));
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    check("sticky_clear", 64'(sticky_flags), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/floating_point_mul_pipe.md
FLOATING_POINT_MUL_PIPE -- requirements
Module: floating_point_mul_pipe

Interface
REQ-001 SHALL have parameter exp_width, default 8, exponent field width.
REQ-002 SHALL have parameter frac_width, default 23, fraction field width.
REQ-003 SHALL have parameter pipe_stages, default 3, op-to-result latency in cycles, legal range 2..6.
REQ-004 SHALL have parameter tag_width, default 4, width of the opaque per-operation tag.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  operands present.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 op1, op2  input  exp_width+frac_width+1  IEEE-style operands, sign in MSB.
REQ-010 round_mode  input  2  FP_ROUND_* encoding from FloatingPointConsts.svh, captured with the operands.
REQ-011 in_tag  input  tag_width  returned unchanged with the result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  exp_width+frac_width+1  product.
REQ-015 out_tag  output  tag_width  tag of the result.
REQ-016 exception  output  5  flags at FP_INVALID, FP_OVERFLOW, FP_UNDERFLOW and FP_INEXACT bit positions; the remaining bit is 0.

Function
REQ-017 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-018 Unstalled, the result SHALL appear on out_valid exactly pipe_stages cycles after the accepting edge; back-to-back ops SHALL sustain 1 result/cycle.
REQ-019 Stall = out_valid & !out_ready; while stalled, every stage, valid bit and tag SHALL hold; in_ready = !stall.
REQ-020 Bubbles SHALL propagate as invalid stages; results SHALL stay in acceptance order.
REQ-021 Stage 1 SHALL decode zero/inf/NaN, flush subnormal inputs to zero, and form the (frac_width+1)x(frac_width+1) mantissa product; extra stages (pipe_stages>2) SHALL be retiming registers inserted between the multiply and normalise/round steps.
REQ-022 The final stage SHALL normalise on the product MSB, build guard/round/sticky bits, round per the captured round_mode, and add the round carry to the exponent.
REQ-023 Biased exponent arithmetic SHALL be exp_width+2 bits wide, so no intermediate wraps.
REQ-024 NaN operand SHALL return that operand (op1 preferred) with the quiet bit set; inf*zero SHALL return {1, all-ones exp, 1, zeros} with FP_INVALID set.
REQ-025 inf*finite-nonzero SHALL return signed inf with no flags.
REQ-026 Biased result exponent <= 0 SHALL return signed zero with FP_UNDERFLOW and FP_INEXACT set.
REQ-027 Biased result exponent >= all-ones SHALL raise FP_OVERFLOW|FP_INEXACT; the result SHALL be inf for TONEAREST, MAX for TOWARDZERO, and for UPWARD/DOWNWARD inf when rounding away from zero, otherwise MAX.
REQ-028 Otherwise FP_INEXACT SHALL equal the OR of the guard, round and sticky bits.
REQ-029 result, out_tag and exception SHALL be registered outputs; they are don't-care while out_valid=0.

Reset
REQ-030 While rst=1, all valid bits, out_valid and exception SHALL clear to 0, and result and out_tag SHALL clear to 0.
REQ-031 in_ready SHALL be 1 during and after reset; in-flight operations SHALL be discarded and SHALL NOT emerge after rst falls.

Configuration
REQ-032 Macro FP_MUL_STICKY_FLAGS_EN defined: the block SHALL add input flags_clear (1) and output sticky_flags (5), a register that ORs in exception on every output transfer. flags_clear SHALL zero the register, take priority over the OR in the same cycle, and reset to 0.
REQ-033 Macro FP_MUL_STICKY_FLAGS_EN undefined: neither port nor the register SHALL exist; all other behaviour SHALL be identical.

Verification (exp_width=8, frac_width=23, pipe_stages=3)
REQ-034 0x40000000*0x40400000, TONEAREST, tag 5 -> 0x40C00000, exception 0, out_tag 5, out_valid exactly 3 cycles after acceptance.
REQ-035 0x7F800000*0x00000000 -> 0xFFC00000, FP_INVALID; 0x7FA00000*0x3F800000 -> 0x7FE00000, no flags.
REQ-036 0x7F7FFFFF*0x40000000 -> 0x7F800000 (TONEAREST), 0x7F7FFFFF (TOWARDZERO), 0x7F7FFFFF (DOWNWARD), 0x7F800000 (UPWARD); all with FP_OVERFLOW|FP_INEXACT.
REQ-037 0x00800000*0x00800000 -> 0x00000000 with FP_UNDERFLOW|FP_INEXACT; 0x80400000 (subnormal)*0x3F800000 -> 0x80000000 via input flush.
REQ-038 Stream 8 ops with tags 0..7 and hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 exactly while stalled, no loss or duplication, tags emerge 0..7 in order.
REQ-039 Assert rst with 3 ops in flight -> out_valid=0 next cycle and no stale result afterwards; with FP_MUL_STICKY_FLAGS_EN, an overflow op then an invalid op -> sticky_flags holds both flags until flags_clear.
